// File: rtl/ocs_slot_scheduler.sv
// Slot/reconfiguration timing engine for the OCS controller: waits for stable links,
// sends START, then loops SLOT -> CONFIG -> SYNC, handing messages to the TX framer.
module ocs_slot_scheduler #(
    parameter int unsigned P_CHANNEL_NUM  = 8,
    parameter logic [31:0] P_SLOT_LEN     = 32'h0000_0708,
    parameter logic [31:0] P_CONFIG_DELAY = 32'h0000_007D,
    parameter int unsigned P_LINK_STABLE  = 16,
    parameter int unsigned P_SLOT_ID_W    = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [P_CHANNEL_NUM-1:0] i_link_up,
    output logic                     o_msg_valid,
    input  logic                     i_msg_ready,
    output logic [1:0]               o_msg_type,
    output logic [P_SLOT_ID_W-1:0]   o_msg_slot_id,
    output logic [15:0]              o_msg_seq,
    output logic [P_SLOT_ID_W-1:0]   o_slot_id,
    output logic                     o_slot_active,
    output logic                     o_ocs_config,
    output logic                     o_link_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SLOT,
        S_CONFIG,
        S_SYNC
    } state_t;

    localparam logic [31:0] STABLE_LAST = 32'(P_LINK_STABLE) - 32'd1;
    localparam logic [31:0] SLOT_LAST   = P_SLOT_LEN - 32'd1;
    localparam logic [31:0] CFG_LAST    = P_CONFIG_DELAY - 32'd1;
    localparam logic [1:0]  TYPE_START  = 2'b01;
    localparam logic [1:0]  TYPE_SYNC   = 2'b10;

    state_t                 state_q, state_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [P_SLOT_ID_W-1:0] slot_id_q, slot_id_d;
    logic [15:0]            seq_q, seq_d;
    logic                   link_err_q, link_err_d;
    logic                   all_up;

    assign all_up = &i_link_up;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            slot_id_q  <= '0;
            seq_q      <= '0;
            link_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_id_q  <= slot_id_d;
            seq_q      <= seq_d;
            link_err_q <= link_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slot_id_d  = slot_id_q;
        seq_d      = seq_q;
        link_err_d = 1'b0;

        // One shared counter: stable-run in IDLE, slot cycles in SLOT, reconfig cycles in CONFIG.
        unique case (state_q)
            S_IDLE: begin
                if (!all_up) begin
                    cnt_d = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_START, S_SYNC: begin
                if (i_msg_ready) begin
                    state_d = S_SLOT;
                    cnt_d   = '0;
                end
            end
            S_SLOT: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d   = S_CONFIG;
                    cnt_d     = '0;
                    slot_id_d = slot_id_q + P_SLOT_ID_W'(1);
                    seq_d     = seq_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_CONFIG: begin
                if (cnt_q == CFG_LAST) begin
                    state_d = S_SYNC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Link loss overrides everything, including a message handshake in the same cycle.
        if (state_q != S_IDLE && !all_up) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            slot_id_d  = '0;
            seq_d      = '0;
            link_err_d = 1'b1;
        end
    end

    assign o_msg_valid   = (state_q == S_START) || (state_q == S_SYNC);
    assign o_msg_type    = (state_q == S_START) ? TYPE_START :
                           (state_q == S_SYNC)  ? TYPE_SYNC  : 2'b00;
    assign o_msg_slot_id = (state_q == S_SYNC) ? slot_id_q : '0;
    assign o_msg_seq     = (state_q == S_SYNC) ? seq_q : 16'd0;
    assign o_slot_id     = slot_id_q;
    assign o_slot_active = (state_q == S_SLOT);
    assign o_ocs_config  = (state_q == S_CONFIG);
    assign o_link_err    = link_err_q;

endmodule

// File: tb/tb_ocs_slot_scheduler.sv
// Bench for ocs_slot_scheduler: directed scenarios with literal timing checks plus
// randomized link/ready traffic compared every cycle against a phase/elapsed-time model.
module tb_ocs_slot_scheduler;

    localparam int SLOT = 20;
    localparam int CFGD = 5;
    localparam int STAB = 4;

    localparam int M_IDLE   = 0;
    localparam int M_START  = 1;
    localparam int M_SLOT   = 2;
    localparam int M_CONFIG = 3;
    localparam int M_SYNC   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  link = 8'hFF;
    logic        ready = 1'b1;
    logic        o_msg_valid;
    logic [1:0]  o_msg_type;
    logic [0:0]  o_msg_slot_id;
    logic [15:0] o_msg_seq;
    logic [0:0]  o_slot_id;
    logic        o_slot_active;
    logic        o_ocs_config;
    logic        o_link_err;

    ocs_slot_scheduler #(
        .P_CHANNEL_NUM (8),
        .P_SLOT_LEN    (32'd20),
        .P_CONFIG_DELAY(32'd5),
        .P_LINK_STABLE (4),
        .P_SLOT_ID_W   (1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_link_up    (link),
        .o_msg_valid  (o_msg_valid),
        .i_msg_ready  (ready),
        .o_msg_type   (o_msg_type),
        .o_msg_slot_id(o_msg_slot_id),
        .o_msg_seq    (o_msg_seq),
        .o_slot_id    (o_slot_id),
        .o_slot_active(o_slot_active),
        .o_ocs_config (o_ocs_config),
        .o_link_err   (o_link_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model: current phase, cycles spent in it, consecutive up cycles, id/seq, error flag
    int m_mode, m_el, m_up, m_id, m_seq;
    bit m_err;

    // timing trackers derived from sampled DUT outputs
    bit prev_act, prev_cfg, err_seen;
    int rise_cyc, last_period, last_run, cfg_rise, cfg_run;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cyc=%0d t=%0t", name, act, exp, cyc, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_el = 0; m_up = 0; m_id = 0; m_seq = 0; m_err = 0;
        prev_act = 0; prev_cfg = 0; err_seen = 0;
        rise_cyc = -1; last_period = 0; last_run = 0; cfg_rise = 0; cfg_run = 0;
    endtask

    task automatic model_step();
        bit all_up;
        all_up = (link == 8'hFF);
        m_err = 0;
        if (m_mode != M_IDLE && !all_up) begin
            m_mode = M_IDLE; m_up = 0; m_id = 0; m_seq = 0; m_err = 1;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_up = all_up ? m_up + 1 : 0;
                    if (m_up == STAB) begin m_mode = M_START; m_up = 0; end
                end
                M_START, M_SYNC: if (ready) begin m_mode = M_SLOT; m_el = 0; end
                M_SLOT: begin
                    m_el++;
                    if (m_el == SLOT) begin
                        m_mode = M_CONFIG; m_el = 0;
                        m_id = (m_id + 1) % 2;
                        m_seq = (m_seq + 1) % 65536;
                    end
                end
                default: begin
                    m_el++;
                    if (m_el == CFGD) begin m_mode = M_SYNC; m_el = 0; end
                end
            endcase
        end
    endtask

    task automatic compare_all();
        bit in_msg;
        in_msg = (m_mode == M_START) || (m_mode == M_SYNC);
        chk("msg_valid", int'(o_msg_valid), int'(in_msg));
        chk("msg_type", int'(o_msg_type), m_mode == M_START ? 1 : (m_mode == M_SYNC ? 2 : 0));
        chk("msg_slot_id", int'(o_msg_slot_id), m_mode == M_SYNC ? m_id : 0);
        chk("msg_seq", int'(o_msg_seq), m_mode == M_SYNC ? m_seq : 0);
        chk("slot_id", int'(o_slot_id), m_id);
        chk("slot_active", int'(o_slot_active), int'(m_mode == M_SLOT));
        chk("ocs_config", int'(o_ocs_config), int'(m_mode == M_CONFIG));
        chk("link_err", int'(o_link_err), int'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        compare_all();
        if (o_slot_active && !prev_act) begin
            if (rise_cyc >= 0) last_period = cyc - rise_cyc;
            rise_cyc = cyc;
        end
        if (!o_slot_active && prev_act) last_run = cyc - rise_cyc;
        if (o_ocs_config && !prev_cfg) cfg_rise = cyc;
        if (!o_ocs_config && prev_cfg) cfg_run = cyc - cfg_rise;
        if (o_link_err) err_seen = 1;
        prev_act = o_slot_active;
        prev_cfg = o_ocs_config;
    endtask

    task automatic tick_until_valid(input int bound, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!o_msg_valid && n < bound);
        chk("valid_reached", int'(o_msg_valid), 1);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        compare_all();
    endtask

    initial begin
        int n, loss_cyc;
        model_reset();
        #1 rst = 1'b1;
        #1;
        chk("reset_valid", int'(o_msg_valid), 0);
        chk("reset_type", int'(o_msg_type), 0);
        chk("reset_active", int'(o_slot_active), 0);
        chk("reset_config", int'(o_ocs_config), 0);
        chk("reset_err", int'(o_link_err), 0);
        release_reset();

        // startup: START on cycle 4
        tick_until_valid(20, n);
        chk("start_cycle", cyc, 4);
        chk("start_type", int'(o_msg_type), 1);
        chk("model_start_mode", m_mode, M_START);

        // first slot/config, then SYNC id 1 seq 1
        tick_until_valid(100, n);
        chk("start_to_sync", n, 26);
        chk("slot_len", last_run, 20);
        chk("config_len", cfg_run, 5);
        chk("sync_type", int'(o_msg_type), 2);
        chk("sync_id", int'(o_msg_slot_id), 1);
        chk("sync_seq", int'(o_msg_seq), 1);

        tick_until_valid(100, n);
        chk("period", last_period, 26);
        chk("sync2_id", int'(o_msg_slot_id), 0);
        chk("sync2_seq", int'(o_msg_seq), 2);

        // backpressure: 7 cycles without ready
        ready = 1'b0;
        repeat (7) begin
            tick();
            chk("bp_valid", int'(o_msg_valid), 1);
            chk("bp_type", int'(o_msg_type), 2);
            chk("bp_id", int'(o_msg_slot_id), 0);
            chk("bp_seq", int'(o_msg_seq), 2);
        end
        ready = 1'b1;
        tick();
        chk("bp_slot_start", int'(o_slot_active), 1);
        chk("bp_period", last_period, 33);

        // link loss at slot cycle 10
        repeat (10) tick();
        link = 8'hF7;
        tick();
        loss_cyc = cyc;
        chk("loss_err", int'(o_link_err), 1);
        chk("loss_active", int'(o_slot_active), 0);
        chk("loss_slot_id", int'(o_slot_id), 0);
        link = 8'hFF;
        tick();
        chk("loss_err_pulse", int'(o_link_err), 0);
        tick_until_valid(20, n);
        chk("restart_delay", cyc - loss_cyc, 4);
        chk("restart_type", int'(o_msg_type), 1);
        tick_until_valid(100, n);
        chk("restart_sync_seq", int'(o_msg_seq), 1);
        chk("restart_sync_id", int'(o_msg_slot_id), 1);

        // async reset while SYNC is valid
        #2 rst = 1'b1;
        #1;
        chk("areset_valid", int'(o_msg_valid), 0);
        chk("areset_type", int'(o_msg_type), 0);
        chk("areset_seq", int'(o_msg_seq), 0);
        chk("areset_slot_id", int'(o_slot_id), 0);
        model_reset();
        release_reset();

        // flicker in IDLE cycle 2
        tick();
        tick();
        link = 8'hFE;
        tick();
        link = 8'hFF;
        tick_until_valid(20, n);
        chk("flicker_start_cycle", cyc, 7);
        chk("flicker_no_err", int'(err_seen), 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            link  = ($urandom_range(0, 59) == 0) ? ~(8'h01 << $urandom_range(0, 7)) : 8'hFF;
            ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
